// File: rtl/cache_tag_ctrl_if.sv
// Bus bundle between the cache control FSM, the tag controller and the
// 4-way tag array.
// The slave modport is the tag controller's view.
// The master modport is the requester/array view.
interface cache_tag_ctrl_if #(
    parameter int bitsDirect  = 10,
    parameter int sizeBitLine = 37
);
    // request / response handshake
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_op;
    logic [bitsDirect-1:0]    req_index;
    logic [sizeBitLine-2:0]   req_tag;
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_hit;
    logic [1:0]               resp_way;
    logic                     resp_evict;
    logic [sizeBitLine-2:0]   resp_evict_tag;
    // tag array access port
    logic [3:0]               tag_write_enable;
    logic                     tag_read_enable;
    logic [bitsDirect-1:0]    tag_adress;
    logic [sizeBitLine-1:0]   tag_data_in;
    logic [sizeBitLine-1:0]   tag_data_out1;
    logic [sizeBitLine-1:0]   tag_data_out2;
    logic [sizeBitLine-1:0]   tag_data_out3;
    logic [sizeBitLine-1:0]   tag_data_out4;

    modport slave (
        input  req_valid, req_op, req_index, req_tag, resp_ready,
               tag_data_out1, tag_data_out2, tag_data_out3, tag_data_out4,
        output req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
               tag_write_enable, tag_read_enable, tag_adress, tag_data_in
    );

    modport master (
        output req_valid, req_op, req_index, req_tag, resp_ready,
               tag_data_out1, tag_data_out2, tag_data_out3, tag_data_out4,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
               tag_write_enable, tag_read_enable, tag_adress, tag_data_in
    );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Lookup/allocation controller for a 4-way tag store.
// It reads a set, compares the tags and picks a victim.
// On an allocate miss it installs the new tag line; on an invalidate hit it
// clears the hit line.
// Line format: [sizeBitLine-1] = valid, [sizeBitLine-2:0] = tag.
// Optional macro CACHE_TAG_PLRU_EN selects per-set tree pseudo-LRU
// replacement. The default is a single global round-robin pointer.
module cache_tag_ctrl #(
    parameter int bitsDirect  = 10,
    parameter int sizeBitLine = 37
) (
    input logic              clk,
    input logic              gen_reset,
    cache_tag_ctrl_if.slave  bus
);
    localparam int TAG_W    = sizeBitLine - 1;
    localparam int NUM_SETS = 1 << bitsDirect;

    typedef enum logic [2:0] {IDLE, READ, CMP, FILL, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   op_q;
    logic [bitsDirect-1:0]  idx_q;
    logic [TAG_W-1:0]       tag_q;
    logic                   hit_q;
    logic [1:0]             hit_way_q;
    logic [1:0]             vic_way_q;
    logic [sizeBitLine-1:0] vic_line_q;
    logic                   resp_hit_q;
    logic [1:0]             resp_way_q;
    logic                   resp_evict_q;
    logic [TAG_W-1:0]       resp_evict_tag_q;

    logic [sizeBitLine-1:0] lines [4];
    logic [3:0]             hit_vec;
    logic                   any_hit;
    logic [1:0]             hit_way;
    logic                   any_invalid;
    logic [1:0]             inv_way;
    logic [1:0]             policy_way;
    logic [1:0]             vic_way;

    assign lines[0] = bus.tag_data_out1;
    assign lines[1] = bus.tag_data_out2;
    assign lines[2] = bus.tag_data_out3;
    assign lines[3] = bus.tag_data_out4;

`ifdef CACHE_TAG_PLRU_EN
    // Tree bits: [0] root (0 = left pair 0/1, 1 = right pair 2/3),
    // [1] chooses between ways 0/1 and [2] chooses between ways 2/3.
    logic [2:0] plru_q [NUM_SETS];
    logic [2:0] plru_cur;

    function automatic logic [1:0] plru_victim(input logic [2:0] t);
        if (!t[0]) plru_victim = t[1] ? 2'd1 : 2'd0;
        else       plru_victim = t[2] ? 2'd3 : 2'd2;
    endfunction

    // Point every tree node on the path away from the accessed way.
    function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] way);
        logic [2:0] n;
        n = t;
        if (!way[1]) begin
            n[0] = 1'b1;
            n[1] = ~way[0];
        end else begin
            n[0] = 1'b0;
            n[2] = ~way[0];
        end
        plru_touch = n;
    endfunction

    assign plru_cur   = plru_q[idx_q];
    assign policy_way = plru_victim(plru_cur);

    // Per-set PLRU update: on a lookup hit in CMP and on an allocating fill.
    // NOTE: this state array is reset because it decides the victim from the first
    // access. A plain RAM without a reset would come up as X.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else if (state_q == CMP && !op_q && hit_q) begin
            plru_q[idx_q] <= plru_touch(plru_cur, hit_way_q);
        end else if (state_q == FILL && !op_q) begin
            plru_q[idx_q] <= plru_touch(plru_cur, vic_way_q);
        end
    end
`else
    logic [1:0] rr_q;
    logic       vic_pol_q;

    assign policy_way = rr_q;

    // Global round-robin pointer: it advances only after a fill whose victim it chose.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            rr_q      <= '0;
            vic_pol_q <= 1'b0;
        end else begin
            if (state_q == READ) vic_pol_q <= ~any_invalid;
            if (state_q == FILL && !op_q && vic_pol_q) rr_q <= rr_q + 2'd1;
        end
    end
`endif

    // Hit compare and victim choice on the lines returned in READ.
    // NOTE: every signal gets a default before the loops. Without one, a path that
    // skips an assignment would infer a latch.
    always_comb begin
        hit_vec     = '0;
        any_hit     = 1'b0;
        hit_way     = 2'd0;
        any_invalid = 1'b0;
        inv_way     = 2'd0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = lines[w][sizeBitLine-1] && (lines[w][TAG_W-1:0] == tag_q);
        end
        // Scan downward so that the lowest matching way is the one kept.
        for (int w = 3; w >= 0; w--) begin
            if (hit_vec[w]) begin
                any_hit = 1'b1;
                hit_way = 2'(w);
            end
            if (!lines[w][sizeBitLine-1]) begin
                any_invalid = 1'b1;
                inv_way     = 2'(w);
            end
        end
        vic_way = any_invalid ? inv_way : policy_way;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples pre-edge values, whatever order the blocks are written in.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = READ;
            READ: state_d = CMP;
            CMP: begin
                if (!op_q) state_d = hit_q ? RESP : FILL;
                else       state_d = hit_q ? FILL : RESP;
            end
            FILL: state_d = RESP;
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, compare results and response registers.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            op_q             <= 1'b0;
            idx_q            <= '0;
            tag_q            <= '0;
            hit_q            <= 1'b0;
            hit_way_q        <= '0;
            vic_way_q        <= '0;
            vic_line_q       <= '0;
            resp_hit_q       <= 1'b0;
            resp_way_q       <= '0;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    op_q  <= bus.req_op;
                    idx_q <= bus.req_index;
                    tag_q <= bus.req_tag;
                end
                READ: begin
                    hit_q      <= any_hit;
                    hit_way_q  <= hit_way;
                    vic_way_q  <= vic_way;
                    vic_line_q <= lines[vic_way];
                end
                CMP: begin
                    resp_hit_q <= hit_q;
                    // The invalidate path fills the hit way. A hit always reports its hit way.
                    if (hit_q)      resp_way_q <= hit_way_q;
                    else if (!op_q) resp_way_q <= vic_way_q;
                    else            resp_way_q <= 2'd0;
                    resp_evict_q     <= !op_q && !hit_q && vic_line_q[sizeBitLine-1];
                    resp_evict_tag_q <= (!op_q && !hit_q && vic_line_q[sizeBitLine-1])
                                        ? vic_line_q[TAG_W-1:0] : '0;
                end
                default: ;
            endcase
        end
    end

    // Array port and handshake outputs. Gating with gen_reset drops a write at once.
    always_comb begin
        bus.req_ready        = (state_q == IDLE);
        bus.resp_valid       = (state_q == RESP);
        bus.resp_hit         = resp_hit_q;
        bus.resp_way         = resp_way_q;
        bus.resp_evict       = resp_evict_q;
        bus.resp_evict_tag   = resp_evict_tag_q;
        bus.tag_read_enable  = (state_q == IDLE) && bus.req_valid && !gen_reset;
        bus.tag_adress       = bus.tag_read_enable ? bus.req_index : idx_q;
        bus.tag_write_enable = '0;
        bus.tag_data_in      = '0;
        if (state_q == FILL && !gen_reset) begin
            bus.tag_write_enable = 4'b0001 << resp_way_q;
            if (!op_q) bus.tag_data_in = {1'b1, tag_q};
        end
    end
endmodule
